// File: rtl/ld_time_arm_trigger_if.sv
`default_nettype none
// ============================================================================
// Module      : ld_time_arm_trigger_if
// Description : Register and status bundle for ld_time_arm_trigger. The
//               master side (software registers plus timestamp source) drives
//               the target time, control word and timestamp. The slave side
//               (the trigger) returns the load pulse and status readback.
// Signals     : ld_time_msw/lsw  target time [63:32]/[31:0]
//               ctrl             bit0 = arm, bit1 = disarm (rising edges act)
//               time_now         free-running 64-bit sample timestamp
//               ld_pulse         timed-load pulse
//               armed, late      status flags
//               fire_cnt         pulses issued, wraps
//               fired_time       timestamp that produced the last hit
// Revision    : 1.0 - initial release
// ============================================================================
interface ld_time_arm_trigger_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ld_time_msw;
  logic [31:0]      ld_time_lsw;
  logic [31:0]      ctrl;
  logic [63:0]      time_now;
  logic             ld_pulse;
  logic             armed;
  logic             late;
  logic [CNT_W-1:0] fire_cnt;
  logic [63:0]      fired_time;

  modport master (
    output ld_time_msw, ld_time_lsw, ctrl, time_now,
    input  ld_pulse, armed, late, fire_cnt, fired_time
  );

  modport slave (
    input  ld_time_msw, ld_time_lsw, ctrl, time_now,
    output ld_pulse, armed, late, fire_cnt, fired_time
  );
endinterface
`default_nettype wire

// File: rtl/ld_time_arm_trigger.sv
`default_nettype none
// ============================================================================
// Module      : ld_time_arm_trigger
// Description : Captures a 64-bit target time on a software arm edge and
//               issues a single PULSE_LEN-cycle load pulse once the free-running
//               timestamp reaches it. The compare runs as a two-stage pipeline
//               split on the 32-bit word boundary.
// Ports       : user_clk  single clock, rising edge
//               user_rst  asynchronous active-high reset
//               bus       ld_time_arm_trigger_if.slave (registers in, status out)
// Parameters  : PULSE_LEN  ld_pulse high time in cycles, 1..255
//               CNT_W      width of fire_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module ld_time_arm_trigger #(
  parameter int PULSE_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  wire logic             user_clk,
  input  wire logic             user_rst,
  ld_time_arm_trigger_if.slave  bus
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       ctrl_prev;
  logic             arm_e;
  logic             dis_e;

  logic [63:0]      target;

  // Compare stage 1
  logic             s1_valid;
  logic             s1_first;
  logic             s1_msw_gt;
  logic             s1_msw_eq;
  logic             s1_lsw_ge;
  logic [63:0]      s1_time;

  logic             hit;
  logic             capture;
  logic             fire;

  logic [7:0]       pulse_cnt;
  logic [7:0]       pulse_cnt_nxt;

  logic             ld_pulse_q;
  logic             armed_q;
  logic             late_q;
  logic [CNT_W-1:0] fire_cnt_q;
  logic [63:0]      fired_time_q;

  assign arm_e = bus.ctrl[0] & ~ctrl_prev[0];
  assign dis_e = bus.ctrl[1] & ~ctrl_prev[1];

  // Compare stage 2: combine the word compares into an unsigned >=.
  assign hit = (state == ARMED) & s1_valid &
               (s1_msw_gt | (s1_msw_eq & s1_lsw_ge));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    fire          = 1'b0;
    pulse_cnt_nxt = pulse_cnt;
    case (state)
      IDLE: begin
        // Simultaneous arm and disarm cancel each other: stay idle.
        if (arm_e && !dis_e) begin
          capture   = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (dis_e) begin
          state_nxt = IDLE;
        end else if (arm_e) begin
          // Re-arm takes priority over a hit: the S1 sample in flight was
          // compared against the old target.
          capture = 1'b1;
        end else if (hit) begin
          fire          = 1'b1;
          state_nxt     = PULSE;
          pulse_cnt_nxt = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (pulse_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= IDLE;
      pulse_cnt  <= 8'd0;
      ld_pulse_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pulse_cnt  <= pulse_cnt_nxt;
      ld_pulse_q <= (state_nxt == PULSE);
      armed_q    <= (state_nxt == ARMED);
    end
  end

  // --------------------------------------------------------------------------
  // Edge detect, target capture and compare stage 1
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ctrl_prev <= 2'b00;
      target    <= 64'd0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_msw_gt <= 1'b0;
      s1_msw_eq <= 1'b0;
      s1_lsw_ge <= 1'b0;
      s1_time   <= 64'd0;
    end else begin
      ctrl_prev <= bus.ctrl[1:0];
      if (capture) begin
        target <= {bus.ld_time_msw, bus.ld_time_lsw};
      end
      // A capture flushes S1; the next sample is the first one against the
      // new target, which is what classifies a hit as late.
      s1_valid  <= ~capture;
      s1_first  <= ~s1_valid;
      s1_msw_gt <= bus.time_now[63:32] >  target[63:32];
      s1_msw_eq <= bus.time_now[63:32] == target[63:32];
      s1_lsw_ge <= bus.time_now[31:0]  >= target[31:0];
      s1_time   <= bus.time_now;
    end
  end

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      late_q       <= 1'b0;
      fire_cnt_q   <= '0;
      fired_time_q <= 64'd0;
    end else begin
      if (capture) begin
        late_q <= 1'b0;
      end else if (fire && s1_first) begin
        late_q <= 1'b1;
      end
      if (fire) begin
        fire_cnt_q   <= fire_cnt_q + 1'b1;
        fired_time_q <= s1_time;
      end
    end
  end

  assign bus.ld_pulse   = ld_pulse_q;
  assign bus.armed      = armed_q;
  assign bus.late       = late_q;
  assign bus.fire_cnt   = fire_cnt_q;
  assign bus.fired_time = fired_time_q;

endmodule
`default_nettype wire
